// File: rtl/sqrt_iter_param.sv
// sqrt_iter_param: iterative integer square-root unit.
//   Computes result = floor(sqrt(num)) and remainder = num - result^2 using a
//   restoring algorithm that retires two radicand bits (one root bit) per clock.
//   Odd WIDTH is zero-extended on the left to an even operand width 2*RW.
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous active-high reset
//   start      request, honoured only while ready=1
//   num        radicand, captured on the accepting edge
//   ready      unit can accept start (idle or done)
//   busy       computation in progress
//   done       one-cycle pulse when result/remainder have just updated
//   result     floor(sqrt(num)), RW bits
//   remainder  num - result^2, RW+1 bits
module sqrt_iter_param #(
  parameter int unsigned WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     start,
  input  logic [WIDTH-1:0]         num,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [(WIDTH+1)/2-1:0]   result,
  output logic [(WIDTH+1)/2:0]     remainder
);

  localparam int unsigned RW = (WIDTH + 1) / 2;
  localparam int unsigned OW = 2 * RW;
  localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] CntInit = CW'(RW - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [OW-1:0] op_q, op_load;
  logic [RW-1:0] root_q, root_iter;
  logic [RW+1:0] rem_q, rem_iter;
  logic [RW+1:0] t, trial, diff;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] result_q;
  logic [RW:0]   remainder_q;
  logic          ge;
  logic          accept;

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  ready = 1'b1;
      StCalc:  busy  = 1'b1;
      StDone: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

  assign accept = start & ready;

  // One restoring iteration. rem never exceeds 2*root, so before the last step it fits
  // RW bits and the left shift by two cannot lose significant bits.
  always_comb begin
    op_load            = '0;
    op_load[WIDTH-1:0] = num;
    t         = (rem_q << 2) | {{RW{1'b0}}, op_q[OW-1 -: 2]};
    trial     = {root_q, 2'b01};
    ge        = (t >= trial);
    diff      = t - trial;
    rem_iter  = ge ? diff : t;
    root_iter = root_q << 1;
    root_iter[0] = ge;
  end

  // Datapath registers; result/remainder only change on the final iteration so a
  // computation aborted by clear never exposes partial values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      op_q        <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
    end else if (accept) begin
      op_q   <= op_load;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= CntInit;
    end else if (state_q == StCalc) begin
      op_q   <= op_q << 2;
      root_q <= root_iter;
      rem_q  <= rem_iter;
      if (cnt_q == '0) begin
        result_q    <= root_iter;
        remainder_q <= rem_iter[RW:0];
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;

endmodule
